// File: rtl/fp_mul_norm_round_pkg.sv
// Shared widths and the stage-1 register layout for the multiplier
// normalize/round back end.
package fp_pkg;

    localparam int PROD_W = 24;
    localparam int MANT_W = 12;
    localparam int FRAC_W = 11;
    localparam int EXP_W  = 6;
    localparam int EIN_W  = 8;
    localparam int BIAS   = 31;
    // Internal exponent width: wide enough that e+1+1+BIAS never wraps.
    localparam int EW     = 10;

    typedef struct packed {
        logic                 sign;
        logic signed [EW-1:0] e;
        logic [MANT_W-1:0]    mant;
        logic                 guard;
        logic                 sticky;
        logic                 zero;
    } s1_t;

    function automatic s1_t normalize(input logic [PROD_W-1:0] prod,
                                      input logic [EIN_W-1:0]  exp_in,
                                      input logic              sign_in);
        s1_t                 r;
        logic signed [EW-1:0] e_ext;
        e_ext  = {{(EW-EIN_W){exp_in[EIN_W-1]}}, exp_in};
        r.sign = sign_in;
        r.zero = (prod == '0);
        if (prod[PROD_W-1]) begin
            r.mant   = prod[PROD_W-1:PROD_W-MANT_W];
            r.guard  = prod[PROD_W-MANT_W-1];
            r.sticky = |prod[PROD_W-MANT_W-2:0];
            r.e      = e_ext + EW'(1);
        end else begin
            r.mant   = prod[PROD_W-2:PROD_W-MANT_W-1];
            r.guard  = prod[PROD_W-MANT_W-2];
            r.sticky = |prod[PROD_W-MANT_W-3:0];
            r.e      = e_ext;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_norm_round_if.sv
// Valid/ready input and result channels of fp_mul_norm_round.
interface fp_mul_norm_round_if;

    logic                        in_valid;
    logic                        in_ready;
    logic [fp_pkg::PROD_W-1:0]   prod;
    logic [fp_pkg::EIN_W-1:0]    exp_in;
    logic                        sign_in;

    logic                        out_valid;
    logic                        out_ready;
    logic                        sign_out;
    logic [fp_pkg::EXP_W-1:0]    exp_out;
    logic [fp_pkg::FRAC_W-1:0]   frac_out;
    logic                        overflow;
    logic                        underflow;
    logic                        inexact;

    modport slave (
        input  in_valid, prod, exp_in, sign_in, out_ready,
        output in_ready, out_valid, sign_out, exp_out, frac_out,
               overflow, underflow, inexact
    );

    modport master (
        output in_valid, prod, exp_in, sign_in, out_ready,
        input  in_ready, out_valid, sign_out, exp_out, frac_out,
               overflow, underflow, inexact
    );

endinterface

// File: rtl/fp_mul_norm_round_rne.sv
// Round-to-nearest-even plus exponent biasing and range clamping
// (flush-to-zero, saturate to max exponent on overflow).
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int BIAS = fp_pkg::BIAS
) (
    input  s1_t               s1,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              overflow,
    output logic              underflow,
    output logic              inexact
);

    localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EZERO = '0;

    logic                 round_up;
    logic [MANT_W:0]      sum;
    logic [MANT_W-1:0]    mant_r;
    logic signed [EW-1:0] e_r;
    logic signed [EW-1:0] biased;

    always_comb begin
        round_up = s1.guard & (s1.sticky | s1.mant[0]);
        sum      = {1'b0, s1.mant} + {{MANT_W{1'b0}}, round_up};
        // Carry out of an all-ones mantissa renormalizes to 1.000... one binade up.
        if (sum[MANT_W]) begin
            mant_r = {1'b1, {(MANT_W-1){1'b0}}};
            e_r    = s1.e + EW'(1);
        end else begin
            mant_r = sum[MANT_W-1:0];
            e_r    = s1.e;
        end
        biased = e_r + EW'(BIAS);

        sign_out  = s1.sign;
        exp_out   = biased[EXP_W-1:0];
        frac_out  = mant_r[FRAC_W-1:0];
        overflow  = 1'b0;
        underflow = 1'b0;
        inexact   = s1.guard | s1.sticky;

        if (s1.zero) begin
            exp_out  = '0;
            frac_out = '0;
            inexact  = 1'b0;
        end else if (biased >= EMAX) begin
            exp_out  = '1;
            frac_out = '0;
            overflow = 1'b1;
            inexact  = 1'b1;
        end else if (biased <= EZERO) begin
            exp_out   = '0;
            frac_out  = '0;
            underflow = 1'b1;
            inexact   = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_norm_round.sv
// Two-stage elastic pipeline: stage 1 normalizes the raw significand
// product, stage 2 registers the rounded, range-checked result.
module fp_mul_norm_round
    import fp_pkg::*;
#(
    parameter int BIAS = fp_pkg::BIAS
) (
    input logic               clk,
    input logic               rstn,
    fp_mul_norm_round_if.slave bus
);

    s1_t               s1_q;
    logic              s1_valid;
    logic              s2_ready;
    logic              s1_ready;

    logic              r_sign;
    logic [EXP_W-1:0]  r_exp;
    logic [FRAC_W-1:0] r_frac;
    logic              r_ovf;
    logic              r_unf;
    logic              r_inx;

    logic              out_valid_q;
    logic              sign_q;
    logic [EXP_W-1:0]  exp_q;
    logic [FRAC_W-1:0] frac_q;
    logic              ovf_q;
    logic              unf_q;
    logic              inx_q;

    assign s2_ready     = ~out_valid_q | bus.out_ready;
    assign s1_ready     = ~s1_valid | s2_ready;
    assign bus.in_ready = s1_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid)
                s1_q <= normalize(bus.prod, bus.exp_in, bus.sign_in);
        end
    end

    fp_round_rne #(.BIAS(BIAS)) u_round (
        .s1        (s1_q),
        .sign_out  (r_sign),
        .exp_out   (r_exp),
        .frac_out  (r_frac),
        .overflow  (r_ovf),
        .underflow (r_unf),
        .inexact   (r_inx)
    );

    // Output registers only move when the consumer can take a new result,
    // so a stalled result stays bit-stable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            frac_q      <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                sign_q <= r_sign;
                exp_q  <= r_exp;
                frac_q <= r_frac;
                ovf_q  <= r_ovf;
                unf_q  <= r_unf;
                inx_q  <= r_inx;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sign_out  = sign_q;
    assign bus.exp_out   = exp_q;
    assign bus.frac_out  = frac_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.inexact   = inx_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed-vector bench for fp_mul_norm_round; results are packed as
// {sign, exp[5:0], frac[10:0], overflow, underflow, inexact}.
module tb_fp_mul_norm_round;

    typedef struct packed {
        logic [23:0] p;
        logic [7:0]  e;
        logic        s;
        logic [20:0] x;
    } vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fp_mul_norm_round_if bus ();

    fp_mul_norm_round #(.BIAS(31)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] observed();
        return {bus.sign_out, bus.exp_out, bus.frac_out,
                bus.overflow, bus.underflow, bus.inexact};
    endfunction

    // Drive one transaction with out_ready high and wait (bounded) for its result.
    task automatic run_one(input logic [23:0] p, input logic [7:0] e, input logic s,
                           output logic [20:0] res, output int lat);
        bus.prod      = p;
        bus.exp_in    = e;
        bus.sign_in   = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        lat = 0;
        res = 'x;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            lat++;
            @(negedge clk);
            if (bus.out_valid) begin
                res = observed();
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run_table(input string name, input vec_t tab[], input int n);
        logic [20:0] res;
        int          lat;
        for (int i = 0; i < n; i++) begin
            run_one(tab[i].p, tab[i].e, tab[i].s, res, lat);
            checks++;
            if (res !== tab[i].x) begin
                errors++;
                $display("FAIL %s[%0d] got %h expected %h", name, i, res, tab[i].x);
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL %s_latency[%0d] got %0d expected 2", name, i, lat);
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.prod      = '0;
        bus.exp_in    = '0;
        bus.sign_in   = 1'b0;
        rstn          = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake got out_valid=%b in_ready=%b expected 0/1",
                     bus.out_valid, bus.in_ready);
        end
        checks++;
        if (observed() !== 21'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 000000", observed());
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_normalize();
        vec_t tab[] = new[5];
        tab[0] = '{24'h400000, 8'd0, 1'b0, {1'b0, 6'd31, 11'h000, 3'b000}};
        tab[1] = '{24'h900000, 8'd0, 1'b1, {1'b1, 6'd32, 11'h100, 3'b000}};
        tab[2] = '{24'h400400, 8'd0, 1'b0, {1'b0, 6'd31, 11'h000, 3'b001}};
        tab[3] = '{24'h400C00, 8'd0, 1'b1, {1'b1, 6'd31, 11'h002, 3'b001}};
        tab[4] = '{24'hC00800, 8'd0, 1'b0, {1'b0, 6'd32, 11'h400, 3'b001}};
        run_table("normalize", tab, 5);
    endtask

    task automatic test_round_carry();
        vec_t tab[] = new[2];
        tab[0] = '{24'h7FFC00, 8'd0, 1'b0, {1'b0, 6'd32, 11'h000, 3'b001}};
        tab[1] = '{24'hFFF800, 8'd0, 1'b1, {1'b1, 6'd33, 11'h000, 3'b001}};
        run_table("round_carry", tab, 2);
    endtask

    task automatic test_range();
        vec_t tab[] = new[8];
        tab[0] = '{24'h400000, 8'd32,  1'b0, {1'b0, 6'd63, 11'h000, 3'b101}};
        tab[1] = '{24'h400000, 8'd31,  1'b0, {1'b0, 6'd62, 11'h000, 3'b000}};
        tab[2] = '{24'h400000, 8'hE1,  1'b1, {1'b1, 6'd0,  11'h000, 3'b011}};
        tab[3] = '{24'h400000, 8'hE2,  1'b0, {1'b0, 6'd1,  11'h000, 3'b000}};
        tab[4] = '{24'h000000, 8'd100, 1'b1, {1'b1, 6'd0,  11'h000, 3'b000}};
        tab[5] = '{24'h7FFC00, 8'd31,  1'b0, {1'b0, 6'd63, 11'h000, 3'b101}};
        tab[6] = '{24'h400000, 8'd127, 1'b0, {1'b0, 6'd63, 11'h000, 3'b101}};
        tab[7] = '{24'h400000, 8'h80,  1'b0, {1'b0, 6'd0,  11'h000, 3'b011}};
        run_table("range", tab, 8);
    endtask

    // 8 inputs offered every cycle while out_ready cycles 1,0,0,1.
    task automatic test_back_to_back();
        int          sent = 0;
        int          rcvd = 0;
        int          cyc  = 0;
        logic        stalled = 1'b0;
        logic        saw_full = 1'b0;
        logic [20:0] held = '0;
        logic [20:0] cur;
        logic [20:0] expv;
        while (rcvd < 8 && cyc < 200) begin
            bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            bus.in_valid  = (sent < 8);
            bus.prod      = 24'h400000 | (24'(sent) << 11);
            bus.exp_in    = 8'(sent);
            bus.sign_in   = sent[0];
            @(negedge clk);
            cur = observed();
            if (stalled) begin
                checks++;
                if (cur !== held || bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold got %h valid=%b expected %h valid=1",
                             cur, bus.out_valid, held);
                end
            end
            if (!bus.in_ready) saw_full = 1'b1;
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                expv = {rcvd[0], 6'(31 + rcvd), 11'(rcvd), 3'b000};
                checks++;
                if (cur !== expv) begin
                    errors++;
                    $display("FAIL b2b_order[%0d] got %h expected %h", rcvd, cur, expv);
                end
                rcvd++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = cur;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (rcvd !== 8) begin
            errors++;
            $display("FAIL b2b_count got %0d expected 8", rcvd);
        end
        checks++;
        if (saw_full !== 1'b1) begin
            errors++;
            $display("FAIL b2b_backpressure got in_ready never low expected a drop");
        end
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_no_extra got out_valid=%b expected 0", bus.out_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    // Consumer always ready: one result per cycle, in_ready never drops.
    task automatic test_throughput();
        int          sent = 0;
        int          rcvd = 0;
        int          first = -1;
        int          last  = -1;
        logic [20:0] expv;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            bus.in_valid = (sent < 4);
            bus.prod     = 24'h400000 | (24'(3 * sent) << 11);
            bus.exp_in   = 8'(sent + 10);
            bus.sign_in  = 1'b1;
            @(negedge clk);
            if (bus.in_valid) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL tput_in_ready[%0d] got %b expected 1", sent, bus.in_ready);
                end
                if (bus.in_ready) sent++;
            end
            if (bus.out_valid) begin
                expv = {1'b1, 6'(41 + rcvd), 11'(3 * rcvd), 3'b000};
                checks++;
                if (observed() !== expv) begin
                    errors++;
                    $display("FAIL tput_data[%0d] got %h expected %h", rcvd, observed(), expv);
                end
                if (first < 0) first = cyc;
                last = cyc;
                rcvd++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (first !== 2 || last !== 5 || rcvd !== 4) begin
            errors++;
            $display("FAIL tput_timing got first=%0d last=%0d n=%0d expected 2/5/4",
                     first, last, rcvd);
        end
    endtask

    task automatic test_reset_midflight();
        logic        leaked = 1'b0;
        logic [20:0] res;
        int          lat;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.prod     = 24'h900000;
            bus.exp_in   = 8'(i);
            bus.sign_in  = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midflight_full got out_valid=%b in_ready=%b expected 1/0",
                     bus.out_valid, bus.in_ready);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || observed() !== 21'h0) begin
            errors++;
            $display("FAIL midflight_reset got valid=%b ready=%b out=%h expected 0/1/000000",
                     bus.out_valid, bus.in_ready, observed());
        end
        @(negedge clk);
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) leaked = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (leaked !== 1'b0) begin
            errors++;
            $display("FAIL midflight_stale got out_valid seen=1 expected 0");
        end
        run_one(24'h400000, 8'd1, 1'b0, res, lat);
        checks++;
        if (res !== {1'b0, 6'd32, 11'h000, 3'b000}) begin
            errors++;
            $display("FAIL midflight_recover got %h expected %h", res,
                     {1'b0, 6'd32, 11'h000, 3'b000});
        end
    endtask

    initial begin
        test_reset();
        test_normalize();
        test_round_carry();
        test_range();
        test_back_to_back();
        test_throughput();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
